// File: rtl/booth_mul_pkg.sv
// Shared encodings and helpers for the iterative radix-4 Booth multiplier.
package booth_mul_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [2:0] {
      DIG_ZERO,
      DIG_POS1,
      DIG_POS2,
      DIG_NEG1,
      DIG_NEG2
   } booth_dig_e;

   // Window is {b[2i+1], b[2i], b[2i-1]}.
   function automatic booth_dig_e booth_decode(input logic [2:0] win);
      booth_dig_e dig;
      case (win)
         3'b001, 3'b010: dig = DIG_POS1;
         3'b011:         dig = DIG_POS2;
         3'b100:         dig = DIG_NEG2;
         3'b101, 3'b110: dig = DIG_NEG1;
         default:        dig = DIG_ZERO;
      endcase
      return dig;
   endfunction

   function automatic int calc_iter(input int xlen, input int pp_per_cycle);
      return ((xlen + 2) / 2 + pp_per_cycle - 1) / pp_per_cycle;
   endfunction

endpackage

// File: rtl/booth_mul_iter_pp_gen.sv
// One radix-4 Booth partial product; negative digits come out inverted and
// the +1 completing the two's complement is returned as neg_o.
module booth_pp_gen
   import booth_mul_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      win_i,
   input  logic [XLEN+1:0] a_ext_i,
   output logic [XLEN+2:0] pp_o,
   output logic            neg_o
);

   logic [XLEN+2:0] a_x1;
   logic [XLEN+2:0] a_x2;

   assign a_x1 = {a_ext_i[XLEN+1], a_ext_i};
   assign a_x2 = {a_ext_i, 1'b0};

   // NOTE: every output gets a default first so no path through this block infers a latch.
   always_comb begin
      pp_o  = '0;
      neg_o = 1'b0;
      case (booth_decode(win_i))
         DIG_POS1: pp_o = a_x1;
         DIG_POS2: pp_o = a_x2;
         DIG_NEG1: begin
            pp_o  = ~a_x1;
            neg_o = 1'b1;
         end
         DIG_NEG2: begin
            pp_o  = ~a_x2;
            neg_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier with ready/valid handshake, flush and
// optional zero-operand early-out.
module booth_mul_iter
   import booth_mul_pkg::*;
#(
   parameter int XLEN         = 64,
   parameter int PP_PER_CYCLE = 1,
   parameter int EARLY_OUT    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mul_flush,
   input  logic            mul_valid,
   output logic            mul_ready,
   input  logic [1:0]      mul_signed,
   input  logic [XLEN-1:0] mul_a,
   input  logic [XLEN-1:0] mul_b,
   output logic            mul_busy,
   input  logic            mul_o_ready,
   output logic            mul_o_valid,
   output logic [XLEN-1:0] mul_result_hi,
   output logic [XLEN-1:0] mul_result_lo
);

   localparam int EW   = XLEN + 2;
   localparam int AW   = 2 * XLEN + 4;
   localparam int NDIG = EW / 2;
   localparam int ITER = calc_iter(XLEN, PP_PER_CYCLE);
   localparam int CW   = $clog2(ITER + 1);
   localparam int BW   = EW + 1 + 2 * PP_PER_CYCLE;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [EW-1:0]   a_q, a_d;
   logic [BW-1:0]   b_q, b_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;

   logic [EW-1:0] a_ext;
   logic [EW-1:0] b_ext;
   assign a_ext = {{2{mul_signed[1] & mul_a[XLEN-1]}}, mul_a};
   assign b_ext = {{2{mul_signed[0] & mul_b[XLEN-1]}}, mul_b};

   // b_q carries a zero below bit 0 so digit g always reads b_q[2g+2:2g].
   logic [PP_PER_CYCLE-1:0][XLEN+2:0] pp;
   logic [PP_PER_CYCLE-1:0]           pp_neg;

   for (genvar g = 0; g < PP_PER_CYCLE; g++) begin : g_pp
      booth_pp_gen #(.XLEN(XLEN)) u_pp_gen (
         .win_i   (b_q[2*g+2 -: 3]),
         .a_ext_i (a_q),
         .pp_o    (pp[g]),
         .neg_o   (pp_neg[g])
      );
   end

   // Digits past NDIG in the final cycle neither add nor shift.
   logic [AW-1:0]   acc_step;
   logic [XLEN+3:0] top_sum;
   logic [AW+1:0]   acc_wide;

   always_comb begin
      acc_step = acc_q;
      top_sum  = '0;
      acc_wide = '0;
      for (int j = 0; j < PP_PER_CYCLE; j++) begin
         if (int'(cnt_q) * PP_PER_CYCLE + j < NDIG) begin
            top_sum  = {{2{acc_step[AW-1]}}, acc_step[AW-1 -: EW]}
                     + {pp[j][XLEN+2], pp[j]}
                     + {{(XLEN+3){1'b0}}, pp_neg[j]};
            acc_wide = {top_sum, acc_step[AW-EW-1:0]};
            acc_step = acc_wide[AW+1:2];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (mul_flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mul_valid) begin
                  a_d   = a_ext;
                  b_d   = {{(2*PP_PER_CYCLE){b_ext[EW-1]}}, b_ext, 1'b0};
                  acc_d = '0;
                  cnt_d = '0;
                  if (EARLY_OUT != 0 && (mul_a == '0 || mul_b == '0)) begin
                     state_d = ST_DONE;
                     hi_d    = '0;
                     lo_d    = '0;
                  end else begin
                     state_d = ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_d = acc_step;
               b_d   = {{(2*PP_PER_CYCLE){b_q[BW-1]}}, b_q[BW-1:2*PP_PER_CYCLE]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(ITER - 1)) begin
                  state_d = ST_DONE;
                  hi_d    = acc_step[2*XLEN-1:XLEN];
                  lo_d    = acc_step[XLEN-1:0];
               end
            end
            ST_DONE: begin
               if (mul_o_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign mul_ready     = (state_q == ST_IDLE);
   assign mul_busy      = (state_q != ST_IDLE);
   assign mul_o_valid   = (state_q == ST_DONE);
   assign mul_result_hi = hi_q;
   assign mul_result_lo = lo_q;

endmodule
